// File: rtl/div8x4_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: a zero divisor completes at once and raises div_zero.
module div8x4_seq #(
  parameter int ITER = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quot,
  output logic [3:0] rem,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_r;
  logic [7:0] work_r;
  logic [3:0] d_r;
  logic [3:0] r_r;
  logic [3:0] cnt_r;

  logic [4:0] r5_s;
  logic [3:0] diff_s;
  logic [3:0] r_next_s;
  logic       q_bit_s;
  logic       last_s;

  // One restoring step; work_r shifts dividend bits out at the MSB and quotient bits in at the LSB.
  always_comb begin
    r5_s     = {r_r, work_r[7]};
    diff_s   = r5_s[3:0] - d_r;
    q_bit_s  = 1'b0;
    r_next_s = r5_s[3:0];
    if (r5_s >= {1'b0, d_r}) begin
      q_bit_s  = 1'b1;
      r_next_s = diff_s;
    end else begin
      q_bit_s  = 1'b0;
      r_next_s = r5_s[3:0];
    end
    last_s = (cnt_r == 4'(ITER - 1));
  end

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      work_r   <= 8'd0;
      d_r      <= 4'd0;
      r_r      <= 4'd0;
      cnt_r    <= 4'd0;
      quot     <= 8'd0;
      rem      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            work_r <= dividend;
            d_r    <= divisor;
            r_r    <= 4'd0;
            cnt_r  <= 4'd0;
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == 4'd0) begin
              quot     <= 8'hFF;
              rem      <= dividend[3:0];
              div_zero <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_r  <= S_DONE;
            end else begin
              busy    <= 1'b1;
              state_r <= S_RUN;
            end
`else
            busy    <= 1'b1;
            state_r <= S_RUN;
`endif
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          work_r <= {work_r[6:0], q_bit_s};
          r_r    <= r_next_s;
          cnt_r  <= cnt_r + 4'd1;
          if (last_s) begin
            quot     <= {work_r[6:0], q_bit_s};
            rem      <= r_next_s;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= S_DONE;
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
          end else begin
            state_r <= S_RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifndef DIV_ZERO_DETECT_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div8x4_seq.sv
// Directed self-checking bench for div8x4_seq; expectations follow DIV_ZERO_DETECT_EN.
module tb_div8x4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quot;
  logic [3:0] rem;
  logic       busy;
  logic       done;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  div8x4_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits at most 20 cycles for done, counting cycles and busy-high cycles.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz,
                       input int elat);
    int lat, bcnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy_cycles"}, bcnt, elat);
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"}, rem, er);
    chk({tag, "_div_zero"}, div_zero, edz);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_quot_hold"}, quot, eq);
  endtask

  initial begin
    int lat, bcnt, ndone;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    tick();
    tick();
    chk("rst_quot", quot, 8'd0);
    chk("rst_rem", rem, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_div_zero", div_zero, 1'b0);
    rst = 1'b0;
    tick();

    do_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    do_op("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
    do_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
    do_op("d0_1", 8'd0, 4'd1, 8'd0, 4'd0, 1'b0, 8);

    // start re-pulsed during RUN must be ignored; previous result 0 r 0 held meanwhile
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("midrun_quot_held", quot, 8'd0);
    chk("midrun_busy", busy, 1'b1);
    wait_done(lat, bcnt);
    chk("midrun_lat", lat, 5);
    chk("midrun_quot", quot, 8'd28);
    chk("midrun_rem", rem, 4'd4);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("midrun_no_second_done", ndone, 0);

    // back-to-back: second start presented in the DONE cycle
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_first_quot", quot, 8'd28);
    dividend = 8'd255;
    divisor  = 4'd15;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done_low", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_first_visible", quot, 8'd28);
    wait_done(lat, bcnt);
    chk("b2b_lat", lat, 8);
    chk("b2b_quot", quot, 8'd17);
    chk("b2b_rem", rem, 4'd0);
    tick();

    // reset during iteration 4 aborts immediately
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_quot", quot, 8'd0);
    chk("midrst_rem", rem, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    do_op("post_rst_5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);

`ifdef DIV_ZERO_DETECT_EN
    do_op("zero_div", 8'hA5, 4'd0, 8'hFF, 4'd5, 1'b1, 0);
    do_op("clear_dz", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
`else
    do_op("zero_div", 8'hA5, 4'd0, 8'hFF, 4'd5, 1'b0, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
